vpe_fea_loader: RTL and testbench
=================================

Name: vpe_fea_loader

Overview:
- Packet-feature front end for the VPE, directly upstream of the VPE controller.
- Accepts per-packet feature words on a valid/ready stream and assembles them into a LANES-wide feature vector in a two-bank ping-pong buffer.
- Hands one vector to the controller per fetch request via the fetch_pkt_fea / pkt_fea_valid handshake.
- Holds the vector stable on fea_vec for the datapath until the next handoff.

Parameters:
- LANES, 8, feature elements per vector.
- WORD_W, 8, bits per feature element.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input feature word valid.
- s_ready  out  1  loader accepts a word this cycle.
- s_data  in  WORD_W  feature element.
- s_last  in  1  last word of the packet.
- fetch_pkt_fea  in  1  controller requests a vector; level signal.
- pkt_fea_valid  out  1  one-cycle pulse: fea_vec updated, controller may start RUN.
- fea_vec  out  LANES*WORD_W  delivered vector; lane 0 in bits [WORD_W-1:0].
- pkt_cnt  out  CNT_W  vectors delivered.
- short_cnt  out  CNT_W  packets zero-padded.
- long_cnt  out  CNT_W  packets truncated.

Behaviour:
- Reset (async, rst_n=0):
  - s_ready=0, pkt_fea_valid=0, fea_vec=0, all counters=0.
  - Both banks empty, lane counter=0, fill FSM=FILL, armed=1.
  - Asserting reset mid-packet discards the partial packet and both banks.
- Banks:
  - Two banks, each LANES x WORD_W, plus a full flag per bank.
  - 1-bit write pointer and 1-bit read pointer; banks are consumed in fill order.
- s_ready is registered-free combinational:
  - FILL state: s_ready = write-pointer bank not full.
  - DRAIN state: s_ready = 1.
  - s_ready may be 1 in the first cycle after reset release.
- Fill FSM, state FILL. On each accepted word (s_valid & s_ready):
  - Write s_data to lane[lcnt] and increment lcnt.
  - s_last with lcnt < LANES-1: zero the remaining lanes, mark the bank full, toggle the write pointer, lcnt=0, short_cnt++.
  - s_last with lcnt == LANES-1: mark the bank full, toggle the write pointer, lcnt=0.
  - No s_last with lcnt == LANES-1: mark the bank full, toggle the write pointer, lcnt=0, long_cnt++, go to DRAIN.
- Fill FSM, state DRAIN:
  - Accept and discard words until an accepted s_last, then return to FILL.
  - The bank already committed stays valid.
- Delivery: when fetch_pkt_fea=1, armed=1 and the read-pointer bank is full, then on the next edge:
  - fea_vec <= that bank; pkt_fea_valid <= 1 for exactly one cycle.
  - Clear that bank's full flag, toggle the read pointer, armed <= 0, pkt_cnt++.
- Re-arm:
  - armed <= 1 on any cycle where fetch_pkt_fea=0.
  - The controller keeps fetch_pkt_fea high for one cycle after the pulse; this rule ensures exactly one pulse per request window.
- Latency:
  - Last word accepted at edge N: the bank is full after edge N.
  - If already requested and armed, pkt_fea_valid is high in the cycle after edge N+1.
- Simultaneous events:
  - Delivery from one bank and completion of the other bank in the same cycle are both honoured.
  - A bank freed in cycle t raises s_ready in cycle t+1, not in the same cycle.
- fea_vec changes only on a delivery edge or reset.
- Counters saturate at all-ones.
- pkt_fea_valid is never asserted while fetch_pkt_fea=0.

Test Plan:
- Exact fit: LANES=8; after reset hold fetch_pkt_fea=1 and send words 1..8 with s_last on word 8 -> one pulse; fea_vec=0x0807060504030201; pkt_cnt=1.
- Short packet: send 3 words 0xA,0xB,0xC with s_last on the 3rd, then request -> fea_vec=0x0000000000_0C0B0A; short_cnt=1.
- Long packet: send 11 words 1..11 with s_last on word 11 -> fea_vec holds words 1..8; s_ready stays 1 through words 9-11; long_cnt=1; the next packet fills the next bank correctly.
- Backpressure: send 3 full packets with no fetch -> s_ready=0 after the 2nd packet completes. Hold fetch_pkt_fea high 3 cycles, then low 2, then high -> exactly 2 pulses, delivering packet 1 then packet 2; packet 3 fills the freed bank.
- Re-arm: model the controller (fetch_pkt_fea falls 2 cycles after the pulse) with 2 banks full -> only one pulse per request window; pkt_cnt increments by 1 per window.
- Reset mid-operation: drive rst_n=0 asynchronously after 4 of 8 words -> outputs immediately reset; a fresh 8-word packet after release is delivered intact with short_cnt=0.

Source files
------------

// File: rtl/vpe_fea_loader_if.sv
// Stream and fetch handshake bundle between the feature source, the loader and
// the VPE controller.
interface vpe_fea_loader_if #(
  parameter int LANES  = 8,
  parameter int WORD_W = 8
) ();
  logic                    s_valid;
  logic                    s_ready;
  logic [WORD_W-1:0]       s_data;
  logic                    s_last;
  logic                    fetch_pkt_fea;
  logic                    pkt_fea_valid;
  logic [LANES*WORD_W-1:0] fea_vec;

  modport master (
    output s_valid, s_data, s_last, fetch_pkt_fea,
    input  s_ready, pkt_fea_valid, fea_vec
  );

  modport slave (
    input  s_valid, s_data, s_last, fetch_pkt_fea,
    output s_ready, pkt_fea_valid, fea_vec
  );
endinterface

// File: rtl/vpe_fea_loader.sv
// Packet-feature front end: assembles streamed feature words into LANES-wide
// vectors in a two-bank ping-pong buffer and hands them to the VPE controller.
module vpe_fea_loader #(
  parameter int LANES  = 8,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  vpe_fea_loader_if.slave  bus,
  output logic [CNT_W-1:0] pkt_cnt_o,
  output logic [CNT_W-1:0] short_cnt_o,
  output logic [CNT_W-1:0] long_cnt_o
);

  localparam int LCNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LCNT_W-1:0] LAST_LANE = LCNT_W'(LANES - 1);
  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [WORD_W-1:0]       bank_q [2][LANES];
  logic [1:0]              full_q, full_d;
  logic                    wptr_q, wptr_d;
  logic                    rptr_q, rptr_d;
  logic [LCNT_W-1:0]       lcnt_q, lcnt_d;
  logic [0:0]              state_q, state_d;
  logic                    armed_q, armed_d;
  logic                    valid_q, valid_d;
  logic [LANES*WORD_W-1:0] vec_q, vec_d, rd_vec;
  logic [CNT_W-1:0]        pkt_q, pkt_d;
  logic [CNT_W-1:0]        short_q, short_d;
  logic [CNT_W-1:0]        long_q, long_d;
  logic                    accept;
  logic                    fill_we;
  logic                    deliver;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  // Held low during reset so nothing is accepted while the buffer is cleared.
  assign bus.s_ready = rst_n & ((state_q == FILL) ? ~full_q[wptr_q] : 1'b1);
  assign accept      = bus.s_valid & bus.s_ready;
  assign fill_we     = accept & (state_q == FILL);
  assign deliver     = bus.fetch_pkt_fea & armed_q & full_q[rptr_q];

  always_comb begin
    rd_vec = '0;
    for (int i = 0; i < LANES; i++) begin
      rd_vec[i*WORD_W +: WORD_W] = bank_q[rptr_q][i];
    end
  end

  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    full_d  = full_q;
    armed_d = armed_q;
    valid_d = 1'b0;
    vec_d   = vec_q;
    pkt_d   = pkt_q;
    short_d = short_q;
    long_d  = long_q;

    if (deliver) begin
      vec_d          = rd_vec;
      valid_d        = 1'b1;
      full_d[rptr_q] = 1'b0;
      rptr_d         = ~rptr_q;
      armed_d        = 1'b0;
      pkt_d          = sat_inc(pkt_q);
    end
    if (!bus.fetch_pkt_fea) begin
      armed_d = 1'b1;
    end

    // The fill bank and the read bank never coincide while the read bank is
    // full, so a commit here and a delivery above never touch the same flag.
    if (accept) begin
      if (state_q == FILL) begin
        if (bus.s_last || (lcnt_q == LAST_LANE)) begin
          full_d[wptr_q] = 1'b1;
          wptr_d         = ~wptr_q;
          lcnt_d         = '0;
          if (bus.s_last && (lcnt_q != LAST_LANE)) begin
            short_d = sat_inc(short_q);
          end
          if (!bus.s_last) begin
            long_d  = sat_inc(long_q);
            state_d = DRAIN;
          end
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end else if (bus.s_last) begin
        state_d = FILL;
      end
    end
  end

  // Short packets zero the lanes above the last written one.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      bank_q[wptr_q][lcnt_q] <= bus.s_data;
      if (bus.s_last) begin
        for (int i = 0; i < LANES; i++) begin
          if (LCNT_W'(i) > lcnt_q) begin
            bank_q[wptr_q][i] <= '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      lcnt_q  <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      full_q  <= '0;
      armed_q <= 1'b1;
      valid_q <= 1'b0;
      vec_q   <= '0;
      pkt_q   <= '0;
      short_q <= '0;
      long_q  <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      armed_q <= armed_d;
      valid_q <= valid_d;
      vec_q   <= vec_d;
      pkt_q   <= pkt_d;
      short_q <= short_d;
      long_q  <= long_d;
    end
  end

  assign bus.pkt_fea_valid = valid_q;
  assign bus.fea_vec       = vec_q;
  assign pkt_cnt_o         = pkt_q;
  assign short_cnt_o       = short_q;
  assign long_cnt_o        = long_q;

endmodule

// File: tb/tb_vpe_fea_loader.sv
// Directed bench for vpe_fea_loader: expected vectors are queued as packets are
// sent and compared against each delivery pulse.
module tb_vpe_fea_loader;

  logic        clk;
  logic        rst_n;
  logic [15:0] pktCnt, shortCnt, longCnt;

  int          vectors = 0;
  int          miscompares = 0;
  int          pulses = 0;
  logic [63:0] expQ[$];
  logic        fetchAtEdge;

  vpe_fea_loader_if #(.LANES(8), .WORD_W(8)) bus ();

  vpe_fea_loader #(.LANES(8), .WORD_W(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .pkt_cnt_o  (pktCnt),
    .short_cnt_o(shortCnt),
    .long_cnt_o (longCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    vectors++;
    miscompares++;
    $error("[TB] FAIL %s: observed timeout expected event", tag);
  endtask

  function automatic logic [63:0] mkVec(input int base, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i*8 +: 8] = 8'(base + i + 1);
    return v;
  endfunction

  // Each delivery pulse is checked against the oldest queued packet.
  always @(posedge clk) begin
    fetchAtEdge = bus.fetch_pkt_fea;
    #1;
    if (rst_n && bus.pkt_fea_valid) begin
      pulses++;
      checkOutput("fetch_at_pulse", fetchAtEdge, 1'b1);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pulse", 64'(expQ.size()), 64'd1);
      end else begin
        checkOutput("fea_vec", bus.fea_vec, expQ.pop_front());
      end
    end
  end

  // Drives one word from a negedge and returns on the negedge after acceptance.
  task automatic applyStimulus(input int d, input logic last);
    int budget;
    budget = 200;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'(d);
    bus.s_last  = last;
    while (!bus.s_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!bus.s_ready) timeoutFail("s_ready_timeout");
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic sendPacket(input int base, input int n);
    for (int k = 1; k <= n; k++) applyStimulus(base + k, k == n);
  endtask

  // Controller model: request until a pulse, keep requesting for hold cycles.
  task automatic fetchOne(input int hold);
    int p;
    int budget;
    p = pulses;
    budget = 200;
    bus.fetch_pkt_fea = 1'b1;
    while (pulses == p && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (pulses == p) timeoutFail("pulse_timeout");
    repeat (hold) @(negedge clk);
    bus.fetch_pkt_fea = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_s_ready"}, bus.s_ready, 1'b0);
    checkOutput({tag, "_valid"}, bus.pkt_fea_valid, 1'b0);
    checkOutput({tag, "_fea_vec"}, bus.fea_vec, 64'd0);
    checkOutput({tag, "_pkt_cnt"}, pktCnt, 64'd0);
    checkOutput({tag, "_short_cnt"}, shortCnt, 64'd0);
    checkOutput({tag, "_long_cnt"}, longCnt, 64'd0);
  endtask

  initial begin
    int p0;
    logic [15:0] c0;
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_last = 1'b0;
    bus.fetch_pkt_fea = 1'b0;
    repeat (2) @(negedge clk);
    checkReset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] exact-fit packet");
    bus.fetch_pkt_fea = 1'b1;
    expQ.push_back(64'h0807060504030201);
    sendPacket(0, 8);
    checkOutput("lat_edge_n", bus.pkt_fea_valid, 1'b0);
    @(negedge clk);
    checkOutput("lat_edge_n1", bus.pkt_fea_valid, 1'b1);
    @(negedge clk);
    checkOutput("pulse_width", bus.pkt_fea_valid, 1'b0);
    checkOutput("exact_pkt_cnt", pktCnt, 64'd1);
    bus.fetch_pkt_fea = 1'b0;
    @(negedge clk);

    $display("[TB] short packet");
    p0 = pulses;
    expQ.push_back(64'h0000000000_0C0B0A);
    sendPacket(9, 3);
    repeat (3) @(negedge clk);
    checkOutput("no_fetch_no_pulse", 64'(pulses), 64'(p0));
    fetchOne(1);
    checkOutput("short_cnt", shortCnt, 64'd1);
    checkOutput("short_pkt_cnt", pktCnt, 64'd2);

    $display("[TB] long packet");
    expQ.push_back(mkVec(0, 8));
    for (int k = 1; k <= 11; k++) begin
      if (k >= 9) checkOutput($sformatf("drain_ready_w%0d", k), bus.s_ready, 1'b1);
      applyStimulus(k, k == 11);
    end
    checkOutput("long_cnt", longCnt, 64'd1);
    expQ.push_back(mkVec(16, 8));
    sendPacket(16, 8);
    fetchOne(1);
    fetchOne(1);
    checkOutput("long_pkt_cnt", pktCnt, 64'd4);
    checkOutput("long_short_cnt", shortCnt, 64'd1);

    $display("[TB] backpressure");
    expQ.push_back(mkVec(32, 8));
    expQ.push_back(mkVec(48, 8));
    sendPacket(32, 8);
    sendPacket(48, 8);
    checkOutput("bp_ready_low", bus.s_ready, 1'b0);
    expQ.push_back(mkVec(64, 8));
    p0 = pulses;
    fork
      sendPacket(64, 8);
      begin
        bus.fetch_pkt_fea = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("bp_window1_pulses", 64'(pulses), 64'(p0 + 1));
        bus.fetch_pkt_fea = 1'b0;
        repeat (2) @(negedge clk);
        fetchOne(1);
        checkOutput("bp_window2_pulses", 64'(pulses), 64'(p0 + 2));
      end
    join
    fetchOne(1);
    checkOutput("bp_pkt_cnt", pktCnt, 64'd7);

    $display("[TB] re-arm");
    expQ.push_back(mkVec(80, 8));
    expQ.push_back(mkVec(96, 8));
    sendPacket(80, 8);
    sendPacket(96, 8);
    p0 = pulses;
    c0 = pktCnt;
    fetchOne(2);
    checkOutput("rearm_pulses1", 64'(pulses), 64'(p0 + 1));
    checkOutput("rearm_cnt1", pktCnt, 64'(c0 + 16'd1));
    fetchOne(2);
    checkOutput("rearm_pulses2", 64'(pulses), 64'(p0 + 2));
    checkOutput("rearm_cnt2", pktCnt, 64'(c0 + 16'd2));

    $display("[TB] reset mid-packet");
    for (int k = 1; k <= 4; k++) applyStimulus(112 + k, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("midreset");
    expQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expQ.push_back(mkVec(64, 8));
    sendPacket(64, 8);
    fetchOne(1);
    checkOutput("post_reset_pkt_cnt", pktCnt, 64'd1);
    checkOutput("post_reset_short_cnt", shortCnt, 64'd0);
    checkOutput("post_reset_long_cnt", longCnt, 64'd0);
    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
